// File: rtl/lcd_pkg.sv
// Shared types and constants for the 4-bit HD44780 nibble writer:
// FSM state encoding, 50 MHz default timing and LCD command codes.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP_HI,
        ST_EN_HI,
        ST_HOLD_HI,
        ST_GAP_NIB,
        ST_SETUP_LO,
        ST_EN_LO,
        ST_HOLD_LO,
        ST_GAP_BYTE
    } lcd_state_e;

    // Default timing in 50 MHz clock cycles (20 ns each).
    localparam int unsigned DEF_SETUP_CYCLES      = 2;
    localparam int unsigned DEF_ENABLE_CYCLES     = 12;
    localparam int unsigned DEF_HOLD_CYCLES       = 1;
    localparam int unsigned DEF_NIBBLE_GAP_CYCLES = 50;
    localparam int unsigned DEF_BYTE_GAP_CYCLES   = 2000;
    localparam int unsigned DEF_LONG_GAP_CYCLES   = 82000;

    localparam logic [7:0] LCD_CMD_CLEAR         = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME          = 8'h02;
    localparam logic [7:0] LCD_CMD_HOME_ALT      = 8'h03;
    localparam logic [7:0] LCD_CMD_ENTRY_MODE    = 8'h06;
    localparam logic [7:0] LCD_CMD_DISPLAY_ON    = 8'h0C;
    localparam logic [7:0] LCD_CMD_FUNC_SET_4BIT = 8'h28;

    // Clear and Return Home need the long post-write wait on the panel.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME ||
                       data == LCD_CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_nibble_writer_if.sv
// Request handshake and LCD pin bundle between the sequencer (master)
// and the nibble writer engine (slave).
interface lcd_nibble_writer_if;

    logic [7:0] iData;
    logic       iRS;
    logic       iNibbleOnly;
    logic       iValid;
    logic       oReady;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_ReadWrite;
    logic       oLCD_StrataFlashControl;
    logic [3:0] oLCD_Data;

    modport master (
        output iData, iRS, iNibbleOnly, iValid,
        input  oReady, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite,
               oLCD_StrataFlashControl, oLCD_Data
    );

    modport slave (
        input  iData, iRS, iNibbleOnly, iValid,
        output oReady, oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite,
               oLCD_StrataFlashControl, oLCD_Data
    );

endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter: load value N-1 on state entry, done is high
// while the count sits at zero, so a state lasts exactly N cycles.
module lcd_delay_counter #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: the default assignment first keeps this purely combinational (no latch).
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Byte-to-nibble write engine for a 4-bit HD44780 LCD. Optional macro
// LCD_LONG_CMD_DELAY_EN stretches the post-write gap after Clear/Home.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES      = DEF_SETUP_CYCLES,
    parameter int unsigned ENABLE_CYCLES     = DEF_ENABLE_CYCLES,
    parameter int unsigned HOLD_CYCLES       = DEF_HOLD_CYCLES,
    parameter int unsigned NIBBLE_GAP_CYCLES = DEF_NIBBLE_GAP_CYCLES,
    parameter int unsigned BYTE_GAP_CYCLES   = DEF_BYTE_GAP_CYCLES,
    parameter int unsigned LONG_GAP_CYCLES   = DEF_LONG_GAP_CYCLES
) (
    input  logic                Clock,
    input  logic                Reset,
    lcd_nibble_writer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(LONG_GAP_CYCLES + 1);

    if (SETUP_CYCLES == 0 || ENABLE_CYCLES == 0 || HOLD_CYCLES == 0 ||
        NIBBLE_GAP_CYCLES == 0 || BYTE_GAP_CYCLES == 0 || LONG_GAP_CYCLES == 0)
    begin : g_param_check
        $error("lcd_nibble_writer: every timing parameter must be at least 1");
    end

    function automatic logic [CNT_W-1:0] cycles_m1(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

    lcd_state_e       state_q, state_d;
    logic [7:0]       data_lat_q, data_lat_d;
    logic             rs_lat_q, rs_lat_d;
    logic             nib_only_q, nib_only_d;
    logic             ready_q, ready_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic [3:0]       db_q, db_d;

    logic             accept;
    logic             long_gap;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_done;

`ifdef LCD_LONG_CMD_DELAY_EN
    assign long_gap = is_long_cmd(rs_lat_q, data_lat_q);
`else
    assign long_gap = 1'b0;
`endif

    assign accept = bus.iValid && ready_q;

    always_comb begin
        state_d        = state_q;
        data_lat_d     = data_lat_q;
        rs_lat_d       = rs_lat_q;
        nib_only_d     = nib_only_q;
        cnt_load_value = '0;

        if (accept) begin
            data_lat_d = bus.iData;
            rs_lat_d   = bus.iRS;
            nib_only_d = bus.iNibbleOnly;
        end

        case (state_q)
            ST_IDLE:     if (accept)   state_d = ST_SETUP_HI;
            ST_SETUP_HI: if (cnt_done) state_d = ST_EN_HI;
            ST_EN_HI:    if (cnt_done) state_d = ST_HOLD_HI;
            ST_HOLD_HI:  if (cnt_done) state_d = nib_only_q ? ST_GAP_BYTE : ST_GAP_NIB;
            ST_GAP_NIB:  if (cnt_done) state_d = ST_SETUP_LO;
            ST_SETUP_LO: if (cnt_done) state_d = ST_EN_LO;
            ST_EN_LO:    if (cnt_done) state_d = ST_HOLD_LO;
            ST_HOLD_LO:  if (cnt_done) state_d = ST_GAP_BYTE;
            ST_GAP_BYTE: if (cnt_done) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase

        // Reload the shared counter on every state entry.
        cnt_load = (state_d != state_q);
        case (state_d)
            ST_SETUP_HI, ST_SETUP_LO: cnt_load_value = cycles_m1(SETUP_CYCLES);
            ST_EN_HI, ST_EN_LO:       cnt_load_value = cycles_m1(ENABLE_CYCLES);
            ST_HOLD_HI, ST_HOLD_LO:   cnt_load_value = cycles_m1(HOLD_CYCLES);
            ST_GAP_NIB:               cnt_load_value = cycles_m1(NIBBLE_GAP_CYCLES);
            ST_GAP_BYTE:              cnt_load_value = long_gap ? cycles_m1(LONG_GAP_CYCLES)
                                                                : cycles_m1(BYTE_GAP_CYCLES);
            default:                  cnt_load_value = '0;
        endcase
    end

    // Pin outputs are registered from the current state, so they trail the
    // state by one cycle; ready is cleared on the accepting edge itself.
    always_comb begin
        ready_d = accept ? 1'b0 : (state_q == ST_IDLE);
        en_d    = (state_q == ST_EN_HI) || (state_q == ST_EN_LO);
        rs_d    = rs_q;
        db_d    = db_q;
        if (state_q == ST_SETUP_HI) begin
            db_d = data_lat_q[7:4];
            rs_d = rs_lat_q;
        end else if (state_q == ST_SETUP_LO) begin
            db_d = data_lat_q[3:0];
            rs_d = rs_lat_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            data_lat_q <= '0;
            rs_lat_q   <= 1'b0;
            nib_only_q <= 1'b0;
            ready_q    <= 1'b1;
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            db_q       <= '0;
        end else begin
            state_q    <= state_d;
            data_lat_q <= data_lat_d;
            rs_lat_q   <= rs_lat_d;
            nib_only_q <= nib_only_d;
            ready_q    <= ready_d;
            en_q       <= en_d;
            rs_q       <= rs_d;
            db_q       <= db_d;
        end
    end

    lcd_delay_counter #(
        .WIDTH (CNT_W)
    ) u_delay_counter (
        .clk        (Clock),
        .rst_n      (Reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .done       (cnt_done)
    );

    assign bus.oReady                  = ready_q;
    assign bus.oLCD_Enabled            = en_q;
    assign bus.oLCD_RegisterSelect     = rs_q;
    assign bus.oLCD_Data               = db_q;
    assign bus.oLCD_ReadWrite          = 1'b0;
    assign bus.oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer: pulse timing, nibble order,
// setup/hold, handshake back-to-back acceptance and mid-pulse reset.
module tb_lcd_nibble_writer;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    lcd_nibble_writer_if bus ();

    lcd_nibble_writer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

`ifdef LCD_LONG_CMD_DELAY_EN
    localparam int CLEAR_OCC = 82081;
`else
    localparam int CLEAR_OCC = 2081;
`endif

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Called right after a negedge with the engine idle. Returns at the
    // negedge sample where oReady is seen high again.
    task automatic run_write(input string tag, input logic [7:0] data, input logic rs,
                             input logic nib, input logic keep_valid, input int exp_pulses,
                             input logic [3:0] exp_hi, input logic [3:0] exp_lo,
                             input int exp_occ);
        int a, n, pulses, rise_n;
        logic e, prev_e, done, rs_h1, rs_h2, rs_rise;
        logic [3:0] db_h1, db_h2, db_rise, exp_nib;
        check({tag, "_ready_pre"}, bus.oReady, 1);
        bus.iData = data;
        bus.iRS = rs;
        bus.iNibbleOnly = nib;
        bus.iValid = 1'b1;
        @(negedge Clock);
        a = cyc;
        if (!keep_valid) bus.iValid = 1'b0;
        check({tag, "_ready_busy"}, bus.oReady, 0);
        prev_e = 1'b0; pulses = 0; rise_n = 0; done = 1'b0;
        db_rise = '0; rs_rise = 1'b0;
        db_h1 = bus.oLCD_Data; db_h2 = db_h1;
        rs_h1 = bus.oLCD_RegisterSelect; rs_h2 = rs_h1;
        while (!done) begin
            n = cyc - a;
            e = bus.oLCD_Enabled;
            if (e && !prev_e) begin
                pulses++;
                exp_nib = (pulses == 1) ? exp_hi : exp_lo;
                check({tag, "_rise_cycle"}, n, (pulses == 1) ? 3 : (pulses == 2) ? 68 : -1);
                check({tag, "_db"}, bus.oLCD_Data, exp_nib);
                check({tag, "_rs"}, bus.oLCD_RegisterSelect, rs);
                check({tag, "_setup"}, {db_h2, db_h1, rs_h2, rs_h1},
                      {bus.oLCD_Data, bus.oLCD_Data, bus.oLCD_RegisterSelect,
                       bus.oLCD_RegisterSelect});
                check({tag, "_rw_sf"}, {bus.oLCD_ReadWrite, bus.oLCD_StrataFlashControl}, 2'b01);
                rise_n = n;
                db_rise = bus.oLCD_Data;
                rs_rise = bus.oLCD_RegisterSelect;
            end
            if (!e && prev_e) begin
                check({tag, "_width"}, n - rise_n, 12);
                check({tag, "_hold"}, {bus.oLCD_Data, bus.oLCD_RegisterSelect}, {db_rise, rs_rise});
            end
            if (bus.oReady) begin
                check({tag, "_ready_cycle"}, n, exp_occ);
                done = 1'b1;
            end else if (n > exp_occ + 100) begin
                check({tag, "_ready_timeout"}, n, exp_occ);
                done = 1'b1;
            end
            db_h2 = db_h1; db_h1 = bus.oLCD_Data;
            rs_h2 = rs_h1; rs_h1 = bus.oLCD_RegisterSelect;
            prev_e = e;
            if (!done) @(negedge Clock);
        end
        check({tag, "_pulses"}, pulses, exp_pulses);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rises, high_seen;
        logic prev_e, reached;
        bus.iData = '0;
        bus.iRS = 1'b0;
        bus.iNibbleOnly = 1'b0;
        bus.iValid = 1'b0;

        #1 Reset = 1'b0;
        #2;
        check("rst_ready", bus.oReady, 1);
        check("rst_en", bus.oLCD_Enabled, 0);
        check("rst_rs", bus.oLCD_RegisterSelect, 0);
        check("rst_db", bus.oLCD_Data, 0);
        check("rst_rw_sf", {bus.oLCD_ReadWrite, bus.oLCD_StrataFlashControl}, 2'b01);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // Data byte 'H': two pulses, 4 then 8.
        run_write("byte48", 8'h48, 1'b1, 1'b0, 1'b0, 2, 4'h4, 4'h8, 2081);
        @(negedge Clock);

        // Power-on style nibble-only write.
        run_write("nib30", 8'h30, 1'b0, 1'b1, 1'b0, 1, 4'h3, 4'h0, 2016);
        @(negedge Clock);

        // iValid held through the busy period; next byte taken on the ready cycle.
        run_write("hold41", 8'h41, 1'b1, 1'b0, 1'b1, 2, 4'h4, 4'h1, 2081);
        run_write("next6c", 8'h6C, 1'b1, 1'b0, 1'b0, 2, 4'h6, 4'hC, 2081);
        @(negedge Clock);

        // Reset during the second enable pulse.
        bus.iData = 8'hA5; bus.iRS = 1'b1; bus.iNibbleOnly = 1'b0; bus.iValid = 1'b1;
        @(negedge Clock);
        bus.iValid = 1'b0;
        rises = 0; prev_e = 1'b0; reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (bus.oLCD_Enabled && !prev_e) rises++;
            prev_e = bus.oLCD_Enabled;
            if (rises == 2 && bus.oLCD_Enabled) reached = 1'b1;
            else @(negedge Clock);
        end
        check("rst_mid_reached_en_lo", reached, 1);
        #2 Reset = 1'b0;
        #1;
        check("rst_mid_en_async", bus.oLCD_Enabled, 0);
        check("rst_mid_ready", bus.oReady, 1);
        check("rst_mid_db", bus.oLCD_Data, 0);
        check("rst_mid_rs", bus.oLCD_RegisterSelect, 0);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        high_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (bus.oLCD_Enabled) high_seen++;
        end
        check("rst_mid_no_resume", high_seen, 0);
        check("rst_mid_ready_after", bus.oReady, 1);

        // Clear command: long gap only when the optional feature is built in.
        run_write("clear01", 8'h01, 1'b0, 1'b0, 1'b0, 2, 4'h0, 4'h1, CLEAR_OCC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_writer.md
Name: lcd_nibble_writer

Overview:
- Byte-to-nibble write engine for the 4-bit character LCD (HD44780-compatible, 50 MHz board clock).
- Sits directly upstream of the LCD pins and below Module_LCD_Control's sequencing logic.
- Accepts one byte (command or data) per valid/ready handshake.
- Emits upper nibble then lower nibble with the required setup, enable-pulse, hold and inter-write delays.

Parameters:
- SETUP_CYCLES, 2, RS/data setup before Enable rises (40 ns).
- ENABLE_CYCLES, 12, Enable high width (240 ns).
- HOLD_CYCLES, 1, data/RS hold after Enable falls.
- NIBBLE_GAP_CYCLES, 50, gap between upper and lower nibble (1 us).
- BYTE_GAP_CYCLES, 2000, wait after a complete write before the next write (40 us).
- LONG_GAP_CYCLES, 82000, post-write wait for Clear/Home; used only with the optional feature.

Ports:
- Clock  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-low reset.
- iData  in  8  byte to write; only [7:4] is used when iNibbleOnly=1.
- iRS  in  1  0 = command, 1 = data.
- iNibbleOnly  in  1  send upper nibble only (power-on init writes 0x3/0x2).
- iValid  in  1  request strobe.
- oReady  out  1  engine idle; accepts a request on this cycle.
- oLCD_Enabled  out  1  LCD E.
- oLCD_RegisterSelect  out  1  LCD RS.
- oLCD_ReadWrite  out  1  LCD RW; constant 0.
- oLCD_StrataFlashControl  out  1  constant 1, keeps StrataFlash off the shared bus.
- oLCD_Data  out  4  LCD DB[7:4].

Behaviour:
- Reset low:
  - State goes to IDLE and counter to 0.
  - oReady=1, oLCD_Enabled=0, oLCD_RegisterSelect=0, oLCD_Data=0, oLCD_ReadWrite=0, oLCD_StrataFlashControl=1.
- Reset may assert at any point, including mid-pulse. Enable drops immediately (asynchronously). No partial write resumes after reset.
- Handshake:
  - A request is accepted when iValid && oReady on a rising edge.
  - iData, iRS and iNibbleOnly are latched at that edge.
  - oReady falls on the next cycle and stays low until the byte gap has fully elapsed.
  - iValid while oReady=0 is ignored. It is not queued.
- States:
  - IDLE.
  - SETUP_HI: oLCD_Data=upper nibble, RS driven, E=0, for SETUP_CYCLES.
  - EN_HI: E=1, for ENABLE_CYCLES.
  - HOLD_HI: E=0, data held, for HOLD_CYCLES.
  - GAP_NIB: NIBBLE_GAP_CYCLES.
  - SETUP_LO, EN_LO, HOLD_LO: same as the _HI states, using the lower nibble.
  - GAP_BYTE: BYTE_GAP_CYCLES, then back to IDLE.
- When iNibbleOnly is latched, HOLD_HI goes directly to GAP_BYTE.
- Each state lasts exactly its parameter count of cycles. A single down-counter is reloaded on every state entry.
- Latency: the first Enable rise occurs SETUP_CYCLES+1 cycles after the accepting edge.
- Full byte occupancy, accept edge to oReady=1:
  - 1 + 2*(SETUP+ENABLE+HOLD) + NIBBLE_GAP + BYTE_GAP cycles, which is 2081 cycles at the defaults.
- Nibble-only occupancy: 1 + SETUP+ENABLE+HOLD + BYTE_GAP = 2016 cycles.
- oLCD_Data and oLCD_RegisterSelect keep their last values during the gaps and in IDLE. They never change while E=1.
- Counter width is $clog2(LONG_GAP_CYCLES+1) (17 bits). All parameters must be at least 1; a value of 0 is illegal and must be asserted in simulation.
- Outputs are registered, with no glitches on E.

Optional Feature:
- Macro: LCD_LONG_CMD_DELAY_EN.
- Defined: if the latched iRS=0 and iData is 8'h01 (Clear) or 8'h02/8'h03 (Return Home), GAP_BYTE uses LONG_GAP_CYCLES instead of BYTE_GAP_CYCLES. Occupancy for 8'h01 becomes 82081 cycles.
- Undefined: every write uses BYTE_GAP_CYCLES. The upstream sequencer must insert its own wait after Clear/Home.

Decomposition:
- Package lcd_pkg holds:
  - the state enum;
  - default timing constants for 50 MHz;
  - LCD command codes (CLEAR=8'h01, HOME=8'h02, ENTRY_MODE=8'h06, DISPLAY_ON=8'h0C, FUNC_SET_4BIT=8'h28).
- One natural sub-module: lcd_delay_counter, a loadable down-counter with a load value and a done flag, instantiated once.

Test Plan:
- Reset released, then iValid=1, iData=8'h48, iRS=1:
  - E rises at cycle +3 with DB=4'h4, RS=1, and stays high 12 cycles.
  - Second pulse carries DB=4'h8.
  - oReady returns at cycle +2081.
- iNibbleOnly=1, iData=8'h30, iRS=0: a single E pulse with DB=4'h3; oReady returns at +2016.
- iValid asserted continuously while busy: only the first byte is emitted; the next is accepted exactly on the oReady=1 cycle.
- Reset driven low during EN_LO: E=0 immediately, oReady=1 after reset release, no further pulse without a new request.
- With LCD_LONG_CMD_DELAY_EN defined, iData=8'h01, iRS=0: oReady returns at +82081. Without the macro it returns at +2081.
- Check setup/hold on every pulse: DB and RS stable 2 cycles before E rises and 1 cycle after E falls. oLCD_ReadWrite=0 and oLCD_StrataFlashControl=1 throughout.
